// File: rtl/bcd_display_mux.sv
// bcd_display_mux: time-multiplexed 4-digit common-anode 7-segment driver for BCD stopwatch digits
// Ports: clk, reset (sync, active-high); BCD0..BCD3 digits (BCD0 = least significant);
// carry sets a sticky overflow shown on digit 3's decimal point; an/seg/dp are active-low.
// Optional: define BCD_DISPLAY_MUX_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  input  logic       carry,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [15:0] snap;
  logic ovf, wrap, blank, hide, show_dp;
  logic [3:0] digit, an_nxt;
  logic [6:0] seg_dec, seg_nxt;
  logic dp_nxt;
  assign wrap  = cnt == CW'(REFRESH_DIV - 1);
  assign blank = cnt < CW'(BLANK_CYCLES);
  assign digit = snap[{state, 2'b00} +: 4];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIG0;
      cnt   <= '0;
      snap  <= '0;
      ovf   <= 1'b0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= wrap ? '0 : cnt + CW'(1);
      // one snapshot per frame keeps all four digits coherent
      if (state == DIG0 && cnt == '0) snap <= {BCD3, BCD2, BCD1, BCD0};
      ovf   <= ovf | carry;
      an    <= an_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
    end
  end
  always_comb begin
    state_nxt = wrap ? state_t'(state + 2'd1) : state;
  end
  always_comb begin
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end
`ifdef BCD_DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  assign hide = (state == DIG3 && snap[15:12] == 4'd0) ||
                (state == DIG2 && snap[15:8] == 8'd0) ||
                (state == DIG1 && snap[15:4] == 12'd0);
`else
  assign hide = 1'b0;
`endif
  always_comb begin
    // a blanked digit 3 still lights its anode so the overflow dot stays visible
    show_dp = !blank && state == DIG3 && ovf;
    an_nxt  = blank || (hide && !show_dp) ? 4'b1111 : ~(4'b0001 << state);
    seg_nxt = blank || hide ? 7'b1111111 : seg_dec;
    dp_nxt  = !show_dp;
  end
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: directed self-checking bench for bcd_display_mux (REFRESH_DIV=4, BLANK_CYCLES=1)
module tb_bcd_display_mux;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic carry;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int n_chk = 0;
  int n_err = 0;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000, SD = 7'b0111111;
`ifdef BCD_DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ1 = 4'b1110;
`else
  localparam logic [3:0] LZ1 = 4'b0000;
`endif
  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .carry(carry), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] hide,
                       input logic dp3, input logic [15:0] nb, input logic cy);
    logic [27:0] sv;
    sv = {s3, s2, s1, s0};
    for (int p = 0; p < 16; p++) begin
      int s;
      logic [3:0] ea;
      logic [6:0] es;
      logic ed;
      s = p / 4;
      @(posedge clk);
      @(negedge clk);
      ea = 4'hf;
      es = 7'h7f;
      ed = 1'b1;
      if (p % 4 != 0) begin
        if (!hide[s]) begin
          ea = ~(4'b0001 << s);
          es = sv[s*7 +: 7];
        end
        if (s == 3 && !dp3) begin
          ed = 1'b0;
          ea = 4'b0111;
        end
      end
      check($sformatf("%s.p%0d.an", name, p), {12'd0, an}, {12'd0, ea});
      check($sformatf("%s.p%0d.seg", name, p), {9'd0, seg}, {9'd0, es});
      check($sformatf("%s.p%0d.dp", name, p), {15'd0, dp}, {15'd0, ed});
      if (p == 9) begin
        {BCD3, BCD2, BCD1, BCD0} = nb;
        carry = cy;
      end
      if (p == 10) carry = 1'b0;
    end
  endtask
  initial begin
    reset = 1'b1;
    carry = 1'b0;
    {BCD3, BCD2, BCD1, BCD0} = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst.an", {12'd0, an}, 16'h000f);
      check("rst.seg", {9'd0, seg}, 16'h007f);
      check("rst.dp", {15'd0, dp}, 16'h0001);
    end
    reset = 1'b0;
    frame("f1", S1, S2, S3, S4, 4'b0000, 1'b1, 16'h1239, 1'b0);
    frame("f2", S1, S2, S3, S9, 4'b0000, 1'b1, 16'h1C39, 1'b0);
    frame("f3", S1, SD, S3, S9, 4'b0000, 1'b0, 16'h1C39, 1'b1);
    frame("f4", S1, SD, S3, S9, 4'b0000, 1'b0, 16'h1C39, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid.an", {12'd0, an}, 16'h000d);
    reset = 1'b1;
    carry = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.an", {12'd0, an}, 16'h000f);
    check("abort.seg", {9'd0, seg}, 16'h007f);
    check("abort.dp", {15'd0, dp}, 16'h0001);
    carry = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2.an", {12'd0, an}, 16'h000f);
    reset = 1'b0;
    frame("f5", S1, SD, S3, S9, 4'b0000, 1'b1, 16'h0005, 1'b0);
    frame("f6", S0, S0, S0, S5, LZ1, 1'b1, 16'h0000, 1'b0);
    frame("f7", S0, S0, S0, S0, LZ1, 1'b0, 16'h0000, 1'b1);
    frame("f8", S0, S0, S0, S0, LZ1, 1'b0, 16'h0000, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
